// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 4-bit processor.
// Owns the program counter, reads the combinational program ROM and resolves
// unconditional JMP locally. Every other instruction goes to the execute stage
// over a valid/ready handshake, where a taken branch can redirect the PC.
module fetch_unit #(
  parameter logic [3:0] JMP_OP = 4'b1011,
  parameter logic [3:0] PC_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  output logic [3:0] pc_addr,
  input  logic [7:0] instr,
  output logic       issue_valid,
  input  logic       issue_ready,
  output logic [3:0] opcode,
  output logic [3:0] imm,
  input  logic       redirect_valid,
  input  logic [3:0] redirect_addr,
  output logic [7:0] issue_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] imm_q, imm_d;
  logic       issue_valid_q, issue_valid_d;
  logic [7:0] issue_count_q, issue_count_d;
  logic       busy_q, busy_d;

  // Next-state logic: one instruction walks FETCH -> DECODE -> (ISSUE) and
  // run_en is only looked at on an instruction boundary.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    opcode_d      = opcode_q;
    imm_d         = imm_q;
    issue_valid_d = issue_valid_q;
    issue_count_d = issue_count_q;

    case (state_q)
      IDLE: begin
        if (run_en) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        // ROM data is valid in the same cycle as pc_addr; PC wraps 15 -> 0.
        ir_d    = instr;
        pc_d    = pc_q + 4'd1;
        state_d = DECODE;
      end
      DECODE: begin
        if (ir_q[7:4] == JMP_OP) begin
          // Jumps never reach the execute stage and cost no issue slot.
          pc_d    = ir_q[3:0];
          state_d = run_en ? FETCH : IDLE;
        end else begin
          opcode_d      = ir_q[7:4];
          imm_d         = ir_q[3:0];
          issue_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        // Hold the instruction until accepted; a redirect only counts on
        // the accepting cycle.
        if (issue_valid_q && issue_ready) begin
          issue_valid_d = 1'b0;
          issue_count_d = issue_count_q + 8'd1;
          if (redirect_valid) begin
            pc_d = redirect_addr;
          end
          state_d = run_en ? FETCH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous active-low reset; reset drops any
  // pending issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= PC_RST;
      ir_q          <= 8'h00;
      opcode_q      <= 4'h0;
      imm_q         <= 4'h0;
      issue_valid_q <= 1'b0;
      issue_count_q <= 8'h00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      opcode_q      <= opcode_d;
      imm_q         <= imm_d;
      issue_valid_q <= issue_valid_d;
      issue_count_q <= issue_count_d;
      busy_q        <= busy_d;
    end
  end

  assign pc_addr     = pc_q;
  assign issue_valid = issue_valid_q;
  assign opcode      = opcode_q;
  assign imm         = imm_q;
  assign issue_count = issue_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: program walk, backpressure, redirect,
// run_en stop/resume, PC wrap, reset mid-issue and issue_count wrap.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n, run_en, issue_ready, redirect_valid;
  logic [3:0] redirect_addr, pc_addr, opcode, imm;
  logic [7:0] instr, issue_count;
  logic       issue_valid, busy;

  logic       rst_n2, run_en2, issue_ready2;
  logic [3:0] pc_addr2, opcode2, imm2;
  logic [7:0] instr2, issue_count2;
  logic       issue_valid2, busy2;

  logic [7:0] rom  [16];
  logic [7:0] rom2 [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instr  = rom[pc_addr];
  assign instr2 = rom2[pc_addr2];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .pc_addr(pc_addr),
    .instr(instr), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .imm(imm), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .issue_count(issue_count), .busy(busy)
  );

  fetch_unit #(.JMP_OP(4'b1011), .PC_RST(4'hF)) dut_wrap (
    .clk(clk), .rst_n(rst_n2), .run_en(run_en2), .pc_addr(pc_addr2),
    .instr(instr2), .issue_valid(issue_valid2), .issue_ready(issue_ready2),
    .opcode(opcode2), .imm(imm2), .redirect_valid(1'b0),
    .redirect_addr(4'h0), .issue_count(issue_count2), .busy(busy2)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run_en = 1'b0; issue_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bounded wait for issue_valid on the main DUT, sampled on negedges.
  task automatic wait_valid(input int budget, output bit ok, output int n);
    ok = 1'b0; n = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (issue_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc_addr !== 4'h0 || issue_valid !== 1'b0 || issue_count !== 8'h00 ||
        busy !== 1'b0 || opcode !== 4'h0 || imm !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%0h valid=%b cnt=%0d busy=%b op=%0h imm=%0h, required 0/0/0/0/0/0",
               pc_addr, issue_valid, issue_count, busy, opcode, imm);
    end
  endtask

  task automatic test_program();
    int  e_op  [9] = '{0, 1, 2, 1, 7, 0, 1, 0, 2};
    int  e_imm [9] = '{8, 9, 0, 0, 0, 0, 4, 4, 0};
    bit  ok;
    int  n;
    do_reset();
    run_en = 1'b1; issue_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_valid(12, ok, n);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL program_timeout: issue %0d not seen within 12 cycles", i);
        return;
      end
      $display("issue %0d: op=%0h imm=%0h cnt=%0d after %0d cycles", i, opcode, imm, issue_count, n);
      checks++;
      if (opcode !== 4'(e_op[i]) || imm !== 4'(e_imm[i])) begin
        errors++;
        $display("FAIL program_issue%0d: got (%0h,%0h), required (%0h,%0h)", i, opcode, imm, e_op[i], e_imm[i]);
      end
      checks++;
      if (issue_count !== 8'(i)) begin
        errors++;
        $display("FAIL program_count%0d: got %0d, required %0d", i, issue_count, i);
      end
      if (i <= 7) begin
        checks++;
        if (n != 3) begin
          errors++;
          $display("FAIL program_spacing%0d: got %0d cycles, required 3", i, n);
        end
      end
      if (i == 7) begin
        @(negedge clk);
        checks++;
        if (pc_addr !== 4'h8) begin
          errors++;
          $display("FAIL jmp_fetch: pc_addr=%0h, required 8", pc_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pc_addr !== 4'h2) begin
          errors++;
          $display("FAIL jmp_target: pc_addr=%0h, required 2", pc_addr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    do_reset();
    run_en = 1'b1; issue_ready = 1'b0;
    wait_valid(12, ok, n);
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    wait_valid(12, ok, n);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || opcode !== 4'h1 || imm !== 4'h9 ||
          pc_addr !== 4'h2 || issue_count !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b op=%0h imm=%0h pc=%0h cnt=%0d, required 1/1/9/2/1",
                 k, issue_valid, opcode, imm, pc_addr, issue_count);
      end
      if (k < 4) @(negedge clk);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 8'd2 || pc_addr !== 4'h2) begin
      errors++;
      $display("FAIL stall_release: valid=%b cnt=%0d pc=%0h, required 0/2/2", issue_valid, issue_count, pc_addr);
    end
  endtask

  // Continues from the FETCH of addr 2 left by test_backpressure.
  task automatic test_redirect();
    bit ok;
    int n;
    issue_ready = 1'b0;
    wait_valid(12, ok, n);
    checks++;
    if (!ok || opcode !== 4'h2 || imm !== 4'h0) begin
      errors++;
      $display("FAIL redir_pre: ok=%b got (%0h,%0h), required (2,0)", ok, opcode, imm);
    end
    redirect_valid = 1'b1; redirect_addr = 4'hC;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1 || pc_addr !== 4'h3) begin
      errors++;
      $display("FAIL redir_stalled: valid=%b pc=%0h, required 1/3", issue_valid, pc_addr);
    end
    issue_ready = 1'b1; redirect_addr = 4'h6;
    @(negedge clk);
    checks++;
    if (pc_addr !== 4'h6 || issue_valid !== 1'b0 || issue_count !== 8'd3) begin
      errors++;
      $display("FAIL redir_taken: pc=%0h valid=%b cnt=%0d, required 6/0/3", pc_addr, issue_valid, issue_count);
    end
    redirect_valid = 1'b0; issue_ready = 1'b0;
    wait_valid(12, ok, n);
    checks++;
    if (!ok || opcode !== 4'h1 || imm !== 4'h4) begin
      errors++;
      $display("FAIL redir_issue: ok=%b got (%0h,%0h), required (1,4)", ok, opcode, imm);
    end
    redirect_valid = 1'b1; redirect_addr = 4'hC;
    @(negedge clk);
    redirect_valid = 1'b0; issue_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_addr !== 4'h7) begin
      errors++;
      $display("FAIL redir_ignored: pc=%0h, required 7", pc_addr);
    end
    wait_valid(12, ok, n);
    checks++;
    if (!ok || opcode !== 4'h0 || imm !== 4'h4) begin
      errors++;
      $display("FAIL redir_after: ok=%b got (%0h,%0h), required (0,4)", ok, opcode, imm);
    end
  endtask

  task automatic test_run_stop();
    bit ok;
    int n;
    do_reset();
    run_en = 1'b1; issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) wait_valid(12, ok, n);
    @(negedge clk);
    checks++;
    if (pc_addr !== 4'h3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_fetch3: pc=%0h busy=%b, required 3/1", pc_addr, busy);
    end
    @(negedge clk);
    run_en = 1'b0;
    wait_valid(4, ok, n);
    checks++;
    if (!ok || n != 1 || opcode !== 4'h1 || imm !== 4'h0) begin
      errors++;
      $display("FAIL stop_issue: ok=%b n=%0d got (%0h,%0h), required 1 cycle (1,0)", ok, n, opcode, imm);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b0 || pc_addr !== 4'h4 || issue_count !== 8'd4) begin
      errors++;
      $display("FAIL stop_idle: valid=%b busy=%b pc=%0h cnt=%0d, required 0/0/4/4", issue_valid, busy, pc_addr, issue_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc_addr !== 4'h4) begin
      errors++;
      $display("FAIL stop_hold: busy=%b pc=%0h, required 0/4", busy, pc_addr);
    end
    run_en = 1'b1;
    wait_valid(8, ok, n);
    checks++;
    if (!ok || n != 3 || opcode !== 4'h7 || imm !== 4'h0) begin
      errors++;
      $display("FAIL stop_resume: ok=%b n=%0d got (%0h,%0h), required 3 cycles (7,0)", ok, n, opcode, imm);
    end
  endtask

  task automatic test_pc_wrap();
    bit ok = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_addr2 !== 4'hF || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: pc=%0h busy=%b, required F/0", pc_addr2, busy2);
    end
    rst_n2 = 1'b1; run_en2 = 1'b1; issue_ready2 = 1'b1;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      if (issue_valid2 === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || opcode2 !== 4'h3 || imm2 !== 4'h1) begin
      errors++;
      $display("FAIL wrap_issue: ok=%b got (%0h,%0h), required (3,1)", ok, opcode2, imm2);
    end
    @(negedge clk);
    checks++;
    if (pc_addr2 !== 4'h0 || busy2 !== 1'b1 || issue_count2 !== 8'd1) begin
      errors++;
      $display("FAIL wrap_fetch: pc=%0h busy=%b cnt=%0d, required 0/1/1", pc_addr2, busy2, issue_count2);
    end
    rst_n2 = 1'b0; run_en2 = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    int n;
    do_reset();
    run_en = 1'b1; issue_ready = 1'b1;
    wait_valid(12, ok, n);
    wait_valid(12, ok, n);
    @(negedge clk);
    issue_ready = 1'b0;
    wait_valid(12, ok, n);
    checks++;
    if (!ok || issue_count !== 8'd2 || opcode !== 4'h2) begin
      errors++;
      $display("FAIL midrst_pre: ok=%b cnt=%0d op=%0h, required 2/2", ok, issue_count, opcode);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || pc_addr !== 4'h0 || issue_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: valid=%b pc=%0h cnt=%0d busy=%b, required 0/0/0/0",
               issue_valid, pc_addr, issue_count, busy);
    end
    rst_n = 1'b1; issue_ready = 1'b1;
    wait_valid(12, ok, n);
    checks++;
    if (!ok || opcode !== 4'h0 || imm !== 4'h8) begin
      errors++;
      $display("FAIL midrst_restart: ok=%b got (%0h,%0h), required (0,8)", ok, opcode, imm);
    end
  endtask

  task automatic test_count_wrap();
    int  seen = 0;
    bit  done = 1'b0;
    do_reset();
    run_en = 1'b1; issue_ready = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (issue_valid === 1'b1) begin
        if (seen == 255) begin
          checks++;
          if (issue_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_count255: got %0d, required 255", issue_count);
          end
          @(negedge clk);
          checks++;
          if (issue_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count0: got %0d, required 0", issue_count);
          end
          done = 1'b1;
        end
        seen++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL count_wrap_timeout: saw %0d issues, required 256", seen);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = 8'hB0;
    rom[0] = 8'h08; rom[1] = 8'h19; rom[2] = 8'h20; rom[3] = 8'h10;
    rom[4] = 8'h70; rom[5] = 8'h00; rom[6] = 8'h14; rom[7] = 8'h04;
    rom[8] = 8'hB2;
    for (int a = 0; a < 16; a++) rom2[a] = rom[a];
    rom2[15] = 8'h31;
    rst_n = 1'b0; run_en = 1'b0; issue_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 4'h0;
    rst_n2 = 1'b0; run_en2 = 1'b0; issue_ready2 = 1'b0;

    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_run_stop();
    test_pc_wrap();
    test_reset_mid_issue();
    test_count_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
